// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control FSM for the multicycle RV32I datapath.
//
// Decodes the instruction register and steps the datapath one state per
// cycle: mux selects, register/memory write enables and the ALU function.
// Memory accesses wait on mem_ready. Opcodes the datapath cannot execute
// (including all shifts) park the FSM in TRAP with a sticky illegal flag.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   instr       instruction register contents (valid from DECODE on)
//   zero, lt    ALU flags, used by branches
//   mem_ready   memory finishes the current access this cycle
//   mem_req     memory access request
//   mem_we      write access (meaningful only with mem_req)
//   adr_src     memory address: 0 PC, 1 alu_out register
//   ir_we       load instruction register and old-PC register
//   pc_we       load PC from result bus
//   rf_we       write rd from result bus
//   alu_src_a   00 PC, 01 old PC, 10 rs1, 11 zero
//   alu_src_b   00 rs2, 01 immediate, 10 constant 4
//   imm_sel     000 I, 001 S, 010 B, 011 U, 100 J
//   result_src  00 alu_out register, 01 memory data, 10 direct ALU result
//   alu_f       000 add, 001 sub, 010 slt, 011 sltu, 100 xor, 110 or, 111 and
//   illegal     sticky trap flag
//
// state     | meaning
// ----------+--------------------------------------------------------
// FETCH     | read instruction at PC, PC+4 -> PC when memory is ready
// DECODE    | check legality, precompute old PC + imm (branch/jal target)
// EXEC_R    | rs1 op rs2
// EXEC_I    | rs1 op imm
// LUI       | 0 + U-immediate
// AUIPC     | old PC + U-immediate
// ALU_WB    | alu_out -> rd
// MEM_ADR   | rs1 + offset for load/store
// MEM_RD    | load access, hold until ready
// MEM_WB    | memory data -> rd
// MEM_WR    | store access, hold until ready
// BRANCH    | compare rs1/rs2, load target into PC if taken
// JAL       | target -> PC, compute link address
// JALR_A    | rs1 + imm
// JALR_PC   | target -> PC, compute link address
// LINK      | link address -> rd
// TRAP      | illegal instruction, frozen until reset

module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        lt,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  imm_sel,
    output logic [1:0]  result_src,
    output logic [2:0]  alu_f,
    output logic        illegal
);

    typedef enum logic [4:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_LUI,
        S_AUIPC,
        S_ALU_WB,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_JALR_A,
        S_JALR_PC,
        S_LINK,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] A_PC     = 2'b00;
    localparam logic [1:0] A_OLD_PC = 2'b01;
    localparam logic [1:0] A_RS1    = 2'b10;
    localparam logic [1:0] A_ZERO   = 2'b11;

    localparam logic [1:0] B_RS2    = 2'b00;
    localparam logic [1:0] B_IMM    = 2'b01;
    localparam logic [1:0] B_FOUR   = 2'b10;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;

    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [2:0] F_ADD    = 3'b000;
    localparam logic [2:0] F_SUB    = 3'b001;
    localparam logic [2:0] F_SLT    = 3'b010;
    localparam logic [2:0] F_SLTU   = 3'b011;

    state_t state;
    state_t state_next;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       f3_shift;
    logic       legal;
    logic [2:0] op_f;
    logic [2:0] branch_f;
    logic       branch_taken;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Register indices and immediate fields belong to the datapath.
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // funct3 001/101 are the shift encodings, which the ALU cannot do.
    assign f3_shift = (funct3[1:0] == 2'b01);

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R:               legal = !f3_shift &&
                                        ((funct7 == 7'b0000000) ||
                                         (funct7 == 7'b0100000 && funct3 == 3'b000));
            OP_I:               legal = !f3_shift;
            OP_LOAD, OP_STORE:  legal = (funct3 == 3'b010);
            OP_BRANCH:          legal = (funct3[2:1] != 2'b01);
            OP_JALR:            legal = (funct3 == 3'b000);
            OP_JAL, OP_LUI,
            OP_AUIPC:           legal = 1'b1;
            default:            legal = 1'b0;
        endcase
    end

    // The remaining ALU codes match funct3 directly; only sub needs funct7.
    always_comb begin
        op_f = funct3;
        if (funct3 == 3'b000) begin
            op_f = (opcode == OP_R && funct7 == 7'b0100000) ? F_SUB : F_ADD;
        end
    end

    // funct3[2] picks the lt-based compares, funct3[1] unsigned,
    // funct3[0] inverts the condition (bne/bge/bgeu).
    always_comb begin
        if (!funct3[2]) begin
            branch_f = F_SUB;
        end else if (!funct3[1]) begin
            branch_f = F_SLT;
        end else begin
            branch_f = F_SLTU;
        end
    end

    assign branch_taken = funct3[2] ? (lt ^ funct3[0]) : (zero ^ funct3[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == S_TRAP) begin
                illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        rf_we      = 1'b0;
        alu_src_a  = A_PC;
        alu_src_b  = B_RS2;
        imm_sel    = IMM_I;
        result_src = RES_ALU_OUT;
        alu_f      = F_ADD;

        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = A_PC;
                alu_src_b  = B_FOUR;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = A_OLD_PC;
                alu_src_b = B_IMM;
                imm_sel   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                if (!legal) begin
                    state_next = S_TRAP;
                end else begin
                    case (opcode)
                        OP_R:              state_next = S_EXEC_R;
                        OP_I:              state_next = S_EXEC_I;
                        OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
                        OP_BRANCH:         state_next = S_BRANCH;
                        OP_JAL:            state_next = S_JAL;
                        OP_JALR:           state_next = S_JALR_A;
                        OP_LUI:            state_next = S_LUI;
                        OP_AUIPC:          state_next = S_AUIPC;
                        default:           state_next = S_TRAP;
                    endcase
                end
            end
            S_EXEC_R: begin
                alu_src_a  = A_RS1;
                alu_src_b  = B_RS2;
                alu_f      = op_f;
                state_next = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a  = A_RS1;
                alu_src_b  = B_IMM;
                imm_sel    = IMM_I;
                alu_f      = op_f;
                state_next = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_a  = A_ZERO;
                alu_src_b  = B_IMM;
                imm_sel    = IMM_U;
                state_next = S_ALU_WB;
            end
            S_AUIPC: begin
                alu_src_a  = A_OLD_PC;
                alu_src_b  = B_IMM;
                imm_sel    = IMM_U;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                rf_we      = 1'b1;
                result_src = RES_ALU_OUT;
                state_next = S_FETCH;
            end
            S_MEM_ADR: begin
                alu_src_a  = A_RS1;
                alu_src_b  = B_IMM;
                imm_sel    = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                rf_we      = 1'b1;
                result_src = RES_MEM;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                // Target was latched into alu_out during DECODE.
                alu_src_a  = A_RS1;
                alu_src_b  = B_RS2;
                alu_f      = branch_f;
                pc_we      = branch_taken;
                result_src = RES_ALU_OUT;
                state_next = S_FETCH;
            end
            S_JAL: begin
                pc_we      = 1'b1;
                result_src = RES_ALU_OUT;
                alu_src_a  = A_OLD_PC;
                alu_src_b  = B_FOUR;
                state_next = S_LINK;
            end
            S_JALR_A: begin
                alu_src_a  = A_RS1;
                alu_src_b  = B_IMM;
                imm_sel    = IMM_I;
                state_next = S_JALR_PC;
            end
            S_JALR_PC: begin
                pc_we      = 1'b1;
                result_src = RES_ALU_OUT;
                alu_src_a  = A_OLD_PC;
                alu_src_b  = B_FOUR;
                state_next = S_LINK;
            end
            S_LINK: begin
                rf_we      = 1'b1;
                result_src = RES_ALU_OUT;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_TRAP;
            end
        endcase

        // Reset silences the datapath in the same cycle, abandoning any
        // outstanding memory access.
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            adr_src    = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            rf_we      = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            imm_sel    = 3'b000;
            result_src = 2'b00;
            alu_f      = 3'b000;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random instruction
// streams, each cycle compared against an instruction-level reference model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        lt;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        adr_src;
    logic        ir_we;
    logic        pc_we;
    logic        rf_we;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  imm_sel;
    logic [1:0]  result_src;
    logic [2:0]  alu_f;
    logic        illegal;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .zero       (zero),
        .lt         (lt),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .adr_src    (adr_src),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .rf_we      (rf_we),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_sel    (imm_sel),
        .result_src (result_src),
        .alu_f      (alu_f),
        .illegal    (illegal)
    );

    // {mem_req, mem_we, adr_src, ir_we, pc_we, rf_we, a, b, imm, res, f, illegal}
    logic [18:0] obs;
    assign obs = {mem_req, mem_we, adr_src, ir_we, pc_we, rf_we, alu_src_a,
                  alu_src_b, imm_sel, result_src, alu_f, illegal};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    endtask

    // One cycle of expected behaviour for an instruction.
    localparam logic [1:0] K_PLAIN = 2'd0;
    localparam logic [1:0] K_FETCH = 2'd1;
    localparam logic [1:0] K_BR    = 2'd2;
    localparam logic [1:0] K_MEM   = 2'd3;

    typedef struct packed {
        logic       req;
        logic       wr;
        logic       adr;
        logic       pc;
        logic       rf;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] imm;
        logic [1:0] rs;
        logic [2:0] f;
        logic [1:0] kind;
    } step_t;

    step_t steps[$];

    function automatic step_t mk(input logic req, input logic wr, input logic adr,
                                 input logic pc, input logic rf, input logic [1:0] a,
                                 input logic [1:0] b, input logic [2:0] imm,
                                 input logic [1:0] rs, input logic [2:0] f,
                                 input logic [1:0] kind);
        step_t s;
        s.req = req; s.wr = wr; s.adr = adr; s.pc = pc; s.rf = rf;
        s.a = a; s.b = b; s.imm = imm; s.rs = rs; s.f = f; s.kind = kind;
        return s;
    endfunction

    // Builds the cycle list for one instruction; ok=0 means it should trap.
    task automatic build(input logic [31:0] ins, output bit ok);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [2:0] fr;
        logic [2:0] fb;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        fr = (op == 7'h33 && f7 == 7'h20) ? 3'd1 : f3;
        fb = (f3 < 3'd2) ? 3'd1 : (f3 < 3'd6) ? 3'd2 : 3'd3;
        case (op)
            7'h33:        ok = (f3 != 3'd1 && f3 != 3'd5) &&
                               (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd0));
            7'h13:        ok = (f3 != 3'd1 && f3 != 3'd5);
            7'h03, 7'h23: ok = (f3 == 3'd2);
            7'h63:        ok = (f3 != 3'd2 && f3 != 3'd3);
            7'h67:        ok = (f3 == 3'd0);
            7'h6F, 7'h37, 7'h17: ok = 1'b1;
            default:      ok = 1'b0;
        endcase
        steps.delete();
        steps.push_back(mk(1,0,0,0,0, 2'd0,2'd2,3'd0,2'd2,3'd0, K_FETCH));
        steps.push_back(mk(0,0,0,0,0, 2'd1,2'd1,(op == 7'h6F) ? 3'd4 : 3'd2,2'd0,3'd0, K_PLAIN));
        if (ok) begin
            case (op)
                7'h33: begin
                    steps.push_back(mk(0,0,0,0,0, 2'd2,2'd0,3'd0,2'd0,fr, K_PLAIN));
                    steps.push_back(mk(0,0,0,0,1, 2'd0,2'd0,3'd0,2'd0,3'd0, K_PLAIN));
                end
                7'h13: begin
                    steps.push_back(mk(0,0,0,0,0, 2'd2,2'd1,3'd0,2'd0,f3, K_PLAIN));
                    steps.push_back(mk(0,0,0,0,1, 2'd0,2'd0,3'd0,2'd0,3'd0, K_PLAIN));
                end
                7'h37, 7'h17: begin
                    steps.push_back(mk(0,0,0,0,0, (op == 7'h37) ? 2'd3 : 2'd1,2'd1,3'd3,2'd0,3'd0, K_PLAIN));
                    steps.push_back(mk(0,0,0,0,1, 2'd0,2'd0,3'd0,2'd0,3'd0, K_PLAIN));
                end
                7'h03: begin
                    steps.push_back(mk(0,0,0,0,0, 2'd2,2'd1,3'd0,2'd0,3'd0, K_PLAIN));
                    steps.push_back(mk(1,0,1,0,0, 2'd0,2'd0,3'd0,2'd0,3'd0, K_MEM));
                    steps.push_back(mk(0,0,0,0,1, 2'd0,2'd0,3'd0,2'd1,3'd0, K_PLAIN));
                end
                7'h23: begin
                    steps.push_back(mk(0,0,0,0,0, 2'd2,2'd1,3'd1,2'd0,3'd0, K_PLAIN));
                    steps.push_back(mk(1,1,1,0,0, 2'd0,2'd0,3'd0,2'd0,3'd0, K_MEM));
                end
                7'h63: steps.push_back(mk(0,0,0,0,0, 2'd2,2'd0,3'd0,2'd0,fb, K_BR));
                7'h6F: begin
                    steps.push_back(mk(0,0,0,1,0, 2'd1,2'd2,3'd0,2'd0,3'd0, K_PLAIN));
                    steps.push_back(mk(0,0,0,0,1, 2'd0,2'd0,3'd0,2'd0,3'd0, K_PLAIN));
                end
                default: begin
                    steps.push_back(mk(0,0,0,0,0, 2'd2,2'd1,3'd0,2'd0,3'd0, K_PLAIN));
                    steps.push_back(mk(0,0,0,1,0, 2'd1,2'd2,3'd0,2'd0,3'd0, K_PLAIN));
                    steps.push_back(mk(0,0,0,0,1, 2'd0,2'd0,3'd0,2'd0,3'd0, K_PLAIN));
                end
            endcase
        end
    endtask

    function automatic logic [18:0] exp_vec(input step_t s, input logic rdy, input logic z,
                                            input logic l, input logic [2:0] f3);
        logic ir;
        logic pc;
        ir = (s.kind == K_FETCH) && rdy;
        pc = s.pc;
        if (s.kind == K_FETCH) pc = rdy;
        if (s.kind == K_BR) begin
            case (f3)
                3'd0:       pc = z;
                3'd1:       pc = !z;
                3'd4, 3'd6: pc = l;
                default:    pc = !l;
            endcase
        end
        return {s.req, s.wr, s.adr, ir, pc, s.rf, s.a, s.b, s.imm, s.rs, s.f, 1'b0};
    endfunction

    bit fix_lt = 1'b0;

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic reset_cycle(input string tag, input logic exp_ill);
        rst       = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        #3;
        check_val(tag, obs, {18'd0, exp_ill});
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_instr(input string name, input logic [31:0] ins, input int fw,
                             input int dw, input bit rnd, input bit rst_in_wait);
        bit   ok;
        int   si;
        int   waited;
        logic rdy;
        logic waits;
        instr = ins;
        build(ins, ok);
        si = 0;
        waited = 0;
        while (si < steps.size()) begin
            if (rnd && $urandom_range(0, 59) == 0) begin
                reset_cycle({name, "_rst_mid"}, 1'b0);
                return;
            end
            if (rst_in_wait && steps[si].kind == K_MEM && waited == 1) begin
                reset_cycle({name, "_rst_wait"}, 1'b0);
                return;
            end
            waits = (steps[si].kind == K_FETCH) || (steps[si].kind == K_MEM);
            if (!waits)   rdy = 1'($urandom_range(0, 1));
            else if (rnd) rdy = (waited >= 4) ? 1'b1 : ($urandom_range(0, 2) != 0);
            else          rdy = (waited >= ((steps[si].kind == K_FETCH) ? fw : dw));
            mem_ready = rdy;
            zero      = 1'($urandom_range(0, 1));
            if (!fix_lt) lt = 1'($urandom_range(0, 1));
            #3;
            check_val($sformatf("%s_c%0d", name, si), obs,
                      exp_vec(steps[si], rdy, zero, lt, ins[14:12]));
            if (waits && !rdy) waited++;
            else begin
                si++;
                waited = 0;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            for (int k = 0; k < 3; k++) begin
                mem_ready = 1'($urandom_range(0, 1));
                #3;
                check_val($sformatf("%s_trap%0d", name, k), obs, 19'd1);
                @(posedge clk); #1;
            end
            reset_cycle({name, "_rst_trap"}, 1'b1);
        end
    endtask

    initial begin
        logic [31:0] ins;
        logic [6:0]  ops [9];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        rst = 1'b1; instr = 32'd0; zero = 1'b0; lt = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        #3;
        check_val("reset", obs, 19'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_instr("add",  32'h002081B3, 0, 0, 0, 0);
        run_instr("sub",  32'h402081B3, 0, 0, 0, 0);
        run_instr("lw",   32'h0000A283, 0, 2, 0, 0);
        run_instr("addi", 32'h00508093, 2, 0, 0, 0);
        fix_lt = 1'b1;
        lt = 1'b0;
        run_instr("bge",  32'h0020D063, 0, 0, 0, 0);
        run_instr("bltu", 32'h0020E063, 0, 0, 0, 0);
        fix_lt = 1'b0;
        run_instr("jalr", 32'h000100E7, 0, 0, 0, 0);
        run_instr("jal",  32'h000000EF, 0, 0, 0, 0);
        run_instr("lui",  32'h123450B7, 0, 0, 0, 0);
        run_instr("sw",   32'h0020A023, 0, 1, 0, 0);
        run_instr("slli", 32'h00109093, 0, 0, 0, 0);
        run_instr("op7f", 32'h0000007F, 0, 0, 0, 0);
        run_instr("sw_rst", 32'h0020A023, 0, 5, 0, 1);
        run_instr("after_rst", 32'h002081B3, 0, 0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            ins = $urandom;
            ins[6:0] = ($urandom_range(0, 19) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            if ((ins[6:0] == 7'h03 || ins[6:0] == 7'h23) && $urandom_range(0, 7) != 0)
                ins[14:12] = 3'd2;
            if (ins[6:0] == 7'h67 && $urandom_range(0, 7) != 0)
                ins[14:12] = 3'd0;
            if (ins[6:0] == 7'h33)
                ins[31:25] = ($urandom_range(0, 7) == 0) ? 7'($urandom) :
                             ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
            run_instr($sformatf("rnd%0d", n), ins, 0, 0, 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
